// File: rtl/lfu_pkg.sv
// Shared types for the LFU replacement core and its request front end.
// Slot index/mask typedefs and the per-slot hold state encoding.
package lfu_pkg;

    localparam int N_SLOTS = 4;
    localparam int HCNT_W  = 4;

    typedef logic [$clog2(N_SLOTS)-1:0] slot_idx_t;
    typedef logic [N_SLOTS-1:0]         slot_mask_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_COUNTING,
        H_FIRED
    } hold_state_t;

endpackage

// File: rtl/req_fifo.sv
// Request queue with a registered head entry.
// A pushed entry becomes visible on dout one cycle after it is written.
module req_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import lfu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    remain;
    logic             head_valid;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = !head_valid;
    assign do_pop  = pop & head_valid;
    assign do_push = push & (!full | do_pop);
    assign rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign remain  = count - CW'(do_pop);

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; count includes the entry shown on dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_nxt;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Head register: loads the entry that will be at the head after
    // this edge, using only entries already written (no bypass).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_valid <= 1'b0;
            dout       <= '0;
        end else begin
            head_valid <= (remain != '0);
            if (remain != '0) begin
                dout <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/lfu_request_gen.sv
// Button front end for the LFU core: synchronise, qualify held presses
// on timer tick edges, and queue slot indices on a valid/ready port.
module lfu_request_gen #(
    parameter int N_SLOTS    = lfu_pkg::N_SLOTS,
    parameter int HOLD_TICKS = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [N_SLOTS-1:0]         btn_raw,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [$clog2(N_SLOTS)-1:0] req_idx,
    output logic                       overflow,
    output logic                       busy
);
    import lfu_pkg::*;

    localparam int IW = $clog2(N_SLOTS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [HCNT_W-1:0] HOLD = HCNT_W'(HOLD_TICKS);

    logic [N_SLOTS-1:0] btn_s1;
    logic [N_SLOTS-1:0] btn_s;
    logic               tick_s1;
    logic               tick_s;
    logic               tick_q;
    logic               tick_rise;

    hold_state_t        hstate   [N_SLOTS];
    hold_state_t        hstate_n [N_SLOTS];
    logic [HCNT_W-1:0]  hcnt     [N_SLOTS];
    logic [HCNT_W-1:0]  hcnt_n   [N_SLOTS];
    logic [N_SLOTS-1:0] ev;

    logic [N_SLOTS-1:0] pending;
    logic [N_SLOTS-1:0] clr;
    logic [N_SLOTS-1:0] lost;
    logic [IW-1:0]      push_idx;
    logic               found;
    logic               do_push;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;

    assign tick_rise = tick_s & ~tick_q;
    assign req_valid = !fifo_empty;
    assign pop       = req_valid & req_ready;
    assign busy      = (|pending) | (fifo_count != '0);

    // Two-flop synchronisers on buttons and tick, plus tick history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1  <= '0;
            btn_s   <= '0;
            tick_s1 <= 1'b0;
            tick_s  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s   <= btn_s1;
            tick_s1 <= tick;
            tick_s  <= tick_s1;
            tick_q  <= tick_s;
        end
    end

    // Per-slot hold FSM state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                hstate[i] <= H_IDLE;
                hcnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                hstate[i] <= hstate_n[i];
                hcnt[i]   <= hcnt_n[i];
            end
        end
    end

    // Hold FSM next state: release always wins, even over a tick edge.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            hstate_n[i] = hstate[i];
            hcnt_n[i]   = hcnt[i];
            ev[i]       = 1'b0;
            if (!btn_s[i]) begin
                hstate_n[i] = H_IDLE;
                hcnt_n[i]   = '0;
            end else if (hstate[i] != H_FIRED) begin
                hstate_n[i] = H_COUNTING;
                if (tick_rise) begin
                    if (hcnt[i] + HCNT_W'(1) == HOLD) begin
                        hcnt_n[i]   = HOLD;
                        hstate_n[i] = H_FIRED;
                        ev[i]       = 1'b1;
                    end else begin
                        hcnt_n[i] = hcnt[i] + HCNT_W'(1);
                    end
                end
            end
        end
    end

    // Pick the lowest pending slot and push it when the queue has room.
    always_comb begin
        found    = 1'b0;
        push_idx = '0;
        clr      = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (pending[i] && !found) begin
                found    = 1'b1;
                push_idx = IW'(i);
            end
        end
        do_push = found & (!fifo_full | pop);
        if (do_push) begin
            clr[push_idx] = 1'b1;
        end
        lost = ev & pending & ~clr;
    end

    // Pending mask and sticky overflow on an event hitting a busy slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | ev;
            overflow <= overflow | (|lost);
        end
    end

    req_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (pop),
        .din   (push_idx),
        .dout  (req_idx),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_lfu_request_gen.sv
// Directed bench for lfu_request_gen with a queue of expected slot indices.
// A negedge monitor pops and compares every accepted request.
module tb_lfu_request_gen;
    import lfu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       req_ready = 1'b0;
    logic       req_valid;
    logic       overflow;
    logic       busy;
    slot_mask_t btn_raw = '0;
    slot_idx_t  req_idx;

    int errors = 0;
    int checks = 0;
    int accepted = 0;
    int base = 0;
    slot_idx_t exp_q[$];

    always #5 clk = ~clk;

    lfu_request_gen dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_raw   (btn_raw),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(4);
        tick = 1'b0;
        cyc(4);
    endtask

    task automatic press(input slot_mask_t m, input int nt);
        btn_raw = m;
        cyc(3);
        repeat (nt) do_tick();
        btn_raw = '0;
        cyc(4);
    endtask

    // Scoreboard: every handshake must match the oldest expected index.
    always @(negedge clk) begin
        if (rst && req_valid && req_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                checks++;
                assert (0) else begin
                    errors++;
                    $error("FAIL unexpected_req: observed idx=%0d expected none",
                           req_idx);
                end
            end else begin
                check("req_idx", 32'(req_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #3 rst = 1'b0;
        btn_raw = slot_mask_t'($urandom);
        tick = 1'($urandom);
        #1;
        check("rst_valid", 32'(req_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (6) begin
            @(posedge clk);
            #1;
            btn_raw = slot_mask_t'($urandom);
            tick = 1'($urandom);
            check("rst_hold_valid", 32'(req_valid), 0);
            check("rst_hold_ovf", 32'(overflow), 0);
            check("rst_hold_busy", 32'(busy), 0);
        end
        btn_raw = '0;
        tick = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(4);

        // Single qualified press on slot 2, then a long hold.
        req_ready = 1'b1;
        base = accepted;
        exp_q.push_back(slot_idx_t'(2));
        btn_raw = 4'b0100;
        cyc(3);
        repeat (2) do_tick();
        cyc(6);
        check("p1_first", 32'(accepted - base), 1);
        repeat (5) do_tick();
        btn_raw = '0;
        cyc(10);
        check("p1_total", 32'(accepted - base), 1);
        check("p1_drain", 32'(exp_q.size()), 0);
        check("p1_busy", 32'(busy), 0);

        // Short presses on slot 0: counter must restart after release.
        base = accepted;
        repeat (2) begin
            btn_raw = 4'b0001;
            cyc(3);
            tick = 1'b1;
            repeat (4) begin
                cyc(1);
                check("short_busy", 32'(busy), 0);
            end
            tick = 1'b0;
            cyc(4);
            btn_raw = '0;
            cyc(4);
        end
        cyc(6);
        check("short_none", 32'(accepted - base), 0);
        check("short_busy_end", 32'(busy), 0);

        // Simultaneous qualification: ascending index order.
        base = accepted;
        exp_q.push_back(slot_idx_t'(0));
        exp_q.push_back(slot_idx_t'(1));
        exp_q.push_back(slot_idx_t'(3));
        press(4'b1011, 2);
        cyc(15);
        check("sim_count", 32'(accepted - base), 3);
        check("sim_drain", 32'(exp_q.size()), 0);

        // Backpressure: fill FIFO, hold one pending, lose one.
        req_ready = 1'b0;
        base = accepted;
        repeat (4) begin
            exp_q.push_back(slot_idx_t'(1));
            press(4'b0010, 2);
        end
        check("bp_valid", 32'(req_valid), 1);
        check("bp_idx", 32'(req_idx), 1);
        check("bp_busy", 32'(busy), 1);
        check("bp_ovf4", 32'(overflow), 0);
        exp_q.push_back(slot_idx_t'(1));
        press(4'b0010, 2);
        check("bp_ovf5", 32'(overflow), 0);
        press(4'b0010, 2);
        check("bp_ovf6", 32'(overflow), 1);
        check("bp_none", 32'(accepted - base), 0);
        req_ready = 1'b1;
        cyc(20);
        check("bp_count", 32'(accepted - base), 5);
        check("bp_drain", 32'(exp_q.size()), 0);
        check("bp_ovf_sticky", 32'(overflow), 1);
        check("bp_busy_end", 32'(busy), 0);

        // Reset with three requests queued discards them all.
        req_ready = 1'b0;
        base = accepted;
        press(4'b0001, 2);
        press(4'b0100, 2);
        press(4'b1000, 2);
        check("mid_valid_pre", 32'(req_valid), 1);
        rst = 1'b0;
        #1;
        check("mid_valid_rst", 32'(req_valid), 0);
        check("mid_ovf_rst", 32'(overflow), 0);
        check("mid_busy_rst", 32'(busy), 0);
        cyc(1);
        rst = 1'b1;
        check("mid_valid_next", 32'(req_valid), 0);
        req_ready = 1'b1;
        cyc(20);
        check("mid_none", 32'(accepted - base), 0);
        check("mid_busy", 32'(busy), 0);

        // Block still works after the reset.
        exp_q.push_back(slot_idx_t'(3));
        press(4'b1000, 2);
        cyc(10);
        check("post_count", 32'(accepted - base), 1);
        check("post_drain", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
